// File: rtl/cap_sense_scheduler.sv
`default_nettype none
// ============================================================================
// cap_sense_scheduler : round-robin charge/discharge scanner for touch pads
// Revision 1.0
// ============================================================================

module cap_sense_scheduler #(
    parameter int NUM_SENSORS      = 4,
    parameter int CNT_W            = 16,
    parameter int MAX_COUNT        = 50000,
    parameter int DISCHARGE_CYCLES = 3000,
    parameter int DEBOUNCE         = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [CNT_W-1:0]               threshold,
    input  logic [NUM_SENSORS-1:0]         sensor_receive,
    output logic [NUM_SENSORS-1:0]         sensor_send,
    output logic [NUM_SENSORS-1:0]         touched,
    output logic [NUM_SENSORS-1:0]         timeout,
    output logic [CNT_W-1:0]               last_count,
    output logic [$clog2(NUM_SENSORS)-1:0] last_channel,
    output logic                           scan_done
);

    localparam int CH_W = $clog2(NUM_SENSORS);
    localparam int DC_W = $clog2(DISCHARGE_CYCLES + 1);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHARGE    = 2'd1,
        DISCHARGE = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DC_W-1:0]          dcnt_q, dcnt_d;
    logic [CNT_W-1:0]         meas_q, meas_d;
    logic                     abort_q, abort_d;
    logic                     stop_q, stop_d;
    logic [NUM_SENSORS-1:0]   rx_meta_q, rx_meta_d;
    logic [NUM_SENSORS-1:0]   rx_s_q, rx_s_d;
    logic [NUM_SENSORS-1:0]   send_q, send_d;
    logic [NUM_SENSORS-1:0]   touched_q, touched_d;
    logic [NUM_SENSORS-1:0]   timeout_q, timeout_d;
    logic [CNT_W-1:0]         last_count_q, last_count_d;
    logic [CH_W-1:0]          last_channel_q, last_channel_d;
    logic                     scan_done_q, scan_done_d;
    logic [DB_W-1:0]          db_q [NUM_SENSORS];
    logic [DB_W-1:0]          db_d [NUM_SENSORS];

    logic                     sample;
    logic [DB_W:0]            db_inc;
    logic                     go_on;

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        dcnt_d         = dcnt_q;
        meas_d         = meas_q;
        abort_d        = abort_q;
        stop_d         = stop_q;
        rx_meta_d      = sensor_receive;
        rx_s_d         = rx_meta_q;
        touched_d      = touched_q;
        timeout_d      = timeout_q;
        last_count_d   = last_count_q;
        last_channel_d = last_channel_q;
        scan_done_d    = 1'b0;
        db_d           = db_q;

        sample = (meas_q > threshold);
        db_inc = {1'b0, db_q[ch_q]} + (DB_W+1)'(1);
        go_on  = enable && !stop_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CHARGE;
                    ch_d    = '0;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            CHARGE: begin
                // Dropping enable abandons this pad; the pad is still discharged fully.
                if (!enable) begin
                    state_d = DISCHARGE;
                    dcnt_d  = '0;
                    abort_d = 1'b1;
                end else if (rx_s_q[ch_q]) begin
                    meas_d          = cnt_q;
                    timeout_d[ch_q] = 1'b0;
                    state_d         = DISCHARGE;
                    dcnt_d          = '0;
                end else if (cnt_q == CNT_W'(MAX_COUNT)) begin
                    meas_d          = CNT_W'(MAX_COUNT);
                    timeout_d[ch_q] = 1'b1;
                    state_d         = DISCHARGE;
                    dcnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DISCHARGE: begin
                if (!enable) begin
                    stop_d = 1'b1;
                end
                if (dcnt_q == DC_W'(DISCHARGE_CYCLES - 1)) begin
                    if (abort_q) begin
                        state_d = IDLE;
                        ch_d    = '0;
                        abort_d = 1'b0;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = UPDATE;
                    end
                end else begin
                    dcnt_d = dcnt_q + DC_W'(1);
                end
            end
            UPDATE: begin
                if (sample != touched_q[ch_q]) begin
                    if (db_inc == (DB_W+1)'(DEBOUNCE)) begin
                        touched_d[ch_q] = ~touched_q[ch_q];
                        db_d[ch_q]      = '0;
                    end else begin
                        db_d[ch_q] = db_inc[DB_W-1:0];
                    end
                end else begin
                    db_d[ch_q] = '0;
                end
                last_count_d   = meas_q;
                last_channel_d = ch_q;
                cnt_d          = '0;
                stop_d         = 1'b0;
                if (ch_q == CH_W'(NUM_SENSORS - 1)) begin
                    scan_done_d = 1'b1;
                    ch_d        = '0;
                    state_d     = go_on ? CHARGE : IDLE;
                end else if (go_on) begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = CHARGE;
                end else begin
                    ch_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Drive is registered so it rises on the first CHARGE cycle and drops on exit.
        send_d = (state_d == CHARGE) ? (NUM_SENSORS'(1) << ch_d) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            cnt_q          <= '0;
            dcnt_q         <= '0;
            meas_q         <= '0;
            abort_q        <= 1'b0;
            stop_q         <= 1'b0;
            rx_meta_q      <= '0;
            rx_s_q         <= '0;
            send_q         <= '0;
            touched_q      <= '0;
            timeout_q      <= '0;
            last_count_q   <= '0;
            last_channel_q <= '0;
            scan_done_q    <= 1'b0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                db_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            dcnt_q         <= dcnt_d;
            meas_q         <= meas_d;
            abort_q        <= abort_d;
            stop_q         <= stop_d;
            rx_meta_q      <= rx_meta_d;
            rx_s_q         <= rx_s_d;
            send_q         <= send_d;
            touched_q      <= touched_d;
            timeout_q      <= timeout_d;
            last_count_q   <= last_count_d;
            last_channel_q <= last_channel_d;
            scan_done_q    <= scan_done_d;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                db_q[i] <= db_d[i];
            end
        end
    end

    assign sensor_send  = send_q;
    assign touched      = touched_q;
    assign timeout      = timeout_q;
    assign last_count   = last_count_q;
    assign last_channel = last_channel_q;
    assign scan_done    = scan_done_q;

endmodule

`default_nettype wire
